// File: rtl/qpd_pkg.sv
// Shared types and constants for the quarter-period-delay sweep sequencer.
package qpd_pkg;

  localparam int MIN_GAP_DEFAULT = 23000;
  localparam int QPD_CNT_W       = 8;

  typedef enum logic [2:0] {
    IDLE,
    PARK,
    ARM,
    WAIT,
    HOLD,
    DONE
  } qpd_state_e;

endpackage

// File: rtl/qpd_delay_table.sv
// Delay-value register file: one synchronous write port, combinational read.
module qpd_delay_table
  import qpd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 sclock,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [QPD_CNT_W-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic [QPD_CNT_W-1:0] rdata
);

  // Contents are undefined after reset; software loads the table before a run.
  logic [QPD_CNT_W-1:0] mem [DEPTH];

  always_ff @(posedge sclock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/qpd_sweep_ctrl.sv
// Sweeps the delay table through the trigger block, with hold-off and repeat count.
//  state | meaning
//  IDLE  | waiting for start; table writable
//  PARK  | strobe count 0 so the next arm always presents a change
//  ARM   | strobe table[step_idx]; a 0 entry skips straight to HOLD
//  WAIT  | waiting for qpd_trigger, bounded by TIMEOUT
//  HOLD  | MIN_GAP hold-off, then next step / next sweep / finish
//  DONE  | one-cycle completion pulse
module qpd_sweep_ctrl
  import qpd_pkg::*;
#(
  parameter int SAMPLE_FREQUENCY = 100000,
  parameter int DEPTH            = 8,
  parameter int MIN_GAP          = MIN_GAP_DEFAULT,
  parameter int TIMEOUT          = 65535,
  localparam int AW              = $clog2(DEPTH)
) (
  input  logic                 sclock,
  input  logic                 rstn,
  input  logic                 cfg_we,
  input  logic [AW-1:0]        cfg_addr,
  input  logic [QPD_CNT_W-1:0] cfg_data,
  input  logic [AW:0]          n_steps,
  input  logic [7:0]           n_sweeps,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 qpd_trigger,
  output logic                 qpd_rt,
  output logic [QPD_CNT_W-1:0] qpd_count,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err,
  output logic [AW-1:0]        step_idx,
  output logic [15:0]          trig_count
);

  localparam int HW = $clog2(MIN_GAP + 1);

  if (SAMPLE_FREQUENCY < 1 || MIN_GAP < 1 || TIMEOUT < 1 || TIMEOUT > 65536 ||
      DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
    $error("qpd_sweep_ctrl: unsupported parameter set");
  end

  qpd_state_e           state_q, state_d;
  logic [AW:0]          n_steps_q;
  logic [7:0]           sweep_cnt;
  logic [15:0]          wait_cnt;
  logic [HW-1:0]        hold_cnt;
  logic [QPD_CNT_W-1:0] tbl_rdata;
  logic                 start_acc;
  logic                 last_step;

  assign start_acc = (state_q == IDLE) && start && !abort;
  assign last_step = ({1'b0, step_idx} == (n_steps_q - 1'b1));

  // A write colliding with an accepted start is dropped, as is any write while busy.
  qpd_delay_table #(.DEPTH(DEPTH), .AW(AW)) u_table (
    .sclock (sclock),
    .we     (cfg_we && (state_q == IDLE) && !start_acc),
    .waddr  (cfg_addr),
    .wdata  (cfg_data),
    .raddr  (step_idx),
    .rdata  (tbl_rdata)
  );

  always_ff @(posedge sclock or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = (n_steps == '0) ? DONE : PARK;
      PARK: state_d = ARM;
      ARM:  state_d = (tbl_rdata == '0) ? HOLD : WAIT;
      WAIT: begin
        if (qpd_trigger)          state_d = HOLD;
        else if (wait_cnt == '0)  state_d = DONE;
      end
      HOLD: if (hold_cnt == '0) state_d = (last_step && sweep_cnt <= 8'd1) ? DONE : PARK;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  assign qpd_rt    = (state_q == PARK) || (state_q == ARM);
  assign qpd_count = (state_q == ARM || state_q == WAIT || state_q == HOLD) ? tbl_rdata : '0;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

  always_ff @(posedge sclock or negedge rstn) begin
    if (!rstn) begin
      n_steps_q   <= '0;
      sweep_cnt   <= '0;
      wait_cnt    <= '0;
      hold_cnt    <= '0;
      step_idx    <= '0;
      trig_count  <= '0;
      timeout_err <= 1'b0;
    end else if (!abort) begin
      unique case (state_q)
        IDLE: if (start) begin
          n_steps_q   <= n_steps;
          sweep_cnt   <= (n_sweeps == 8'd0) ? 8'd1 : n_sweeps;
          trig_count  <= '0;
          timeout_err <= 1'b0;
          step_idx    <= '0;
        end
        ARM: begin
          wait_cnt <= 16'(TIMEOUT - 1);
          hold_cnt <= HW'(MIN_GAP - 1);
        end
        WAIT: begin
          if (qpd_trigger) begin
            if (trig_count != 16'hFFFF) trig_count <= trig_count + 16'd1;
          end else if (wait_cnt == '0) begin
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 16'd1;
          end
        end
        HOLD: begin
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
          end else if (last_step) begin
            step_idx  <= '0;
            sweep_cnt <= sweep_cnt - 8'd1;
          end else begin
            step_idx <= step_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qpd_sweep_ctrl.sv
// Scoreboard bench for qpd_sweep_ctrl with a behavioural trigger-block model.
module tb_qpd_sweep_ctrl;

  localparam int DEPTH   = 8;
  localparam int AW      = 3;
  localparam int MIN_GAP = 20;
  localparam int TIMEOUT = 100;

  logic          sclock = 1'b0;
  logic          rstn = 1'b0;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [7:0]    cfg_data = '0;
  logic [AW:0]   n_steps = '0;
  logic [7:0]    n_sweeps = '0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          qpd_trigger = 1'b0;
  logic          qpd_rt;
  logic [7:0]    qpd_count;
  logic          busy;
  logic          done;
  logic          timeout_err;
  logic [AW-1:0] step_idx;
  logic [15:0]   trig_count;

  qpd_sweep_ctrl #(
    .SAMPLE_FREQUENCY(100000), .DEPTH(DEPTH), .MIN_GAP(MIN_GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .sclock(sclock), .rstn(rstn), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .n_steps(n_steps), .n_sweeps(n_sweeps), .start(start),
    .abort(abort), .qpd_trigger(qpd_trigger), .qpd_rt(qpd_rt), .qpd_count(qpd_count),
    .busy(busy), .done(done), .timeout_err(timeout_err), .step_idx(step_idx),
    .trig_count(trig_count)
  );

  always #5 sclock = ~sclock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge sclock) cyc <= cyc + 1;

  typedef struct {
    int start_cyc;
    int dur;
    int trig;
    int terr;
  } done_exp_t;

  done_exp_t exp_done_q[$];
  int        exp_arm_q[$];
  int        exp_idx_q[$];
  int        mirror[DEPTH];
  bit        trig_en = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Trigger block: pulses qpd_trigger 'count' cycles after it sees an arm.
  initial begin : trig_model
    int cd;
    cd = 0;
    forever begin
      @(negedge sclock);
      qpd_trigger = 1'b0;
      if (!busy) cd = 0;
      else if (cd > 0) begin
        cd--;
        if (cd == 0) qpd_trigger = 1'b1;
      end
      if (trig_en && qpd_rt && qpd_count != 8'd0) cd = int'(qpd_count);
    end
  end

  initial begin : monitor
    bit prev_rt;
    int prev_cnt;
    bit after_done;
    done_exp_t e;
    prev_rt = 1'b0; prev_cnt = 0; after_done = 1'b0;
    forever begin
      @(negedge sclock);
      if (!rstn) begin
        prev_rt = 1'b0; prev_cnt = 0; after_done = 1'b0;
        continue;
      end
      if (after_done) begin
        check("idle_after_done_busy", int'(busy), 0);
        check("idle_after_done_rt", int'(qpd_rt), 0);
        after_done = 1'b0;
      end
      if (qpd_rt && qpd_count != 8'd0) begin
        check("park_before_arm", int'(prev_rt && prev_cnt == 0), 1);
        if (exp_arm_q.size() == 0) check("unexpected_arm", int'(qpd_count), 0);
        else begin
          check("arm_count", int'(qpd_count), exp_arm_q.pop_front());
          check("arm_step_idx", int'(step_idx), exp_idx_q.pop_front());
        end
      end
      if (done) begin
        if (exp_done_q.size() == 0) check("unexpected_done", int'(done), 0);
        else begin
          e = exp_done_q.pop_front();
          check("run_cycles", cyc - e.start_cyc, e.dur);
          check("trig_count", int'(trig_count), e.trig);
          check("timeout_err", int'(timeout_err), e.terr);
          check("done_qpd_count", int'(qpd_count), 0);
        end
        after_done = 1'b1;
      end
      prev_rt  = qpd_rt;
      prev_cnt = int'(qpd_count);
    end
  end

  task automatic write_tbl(input int addr, input int data);
    @(negedge sclock);
    cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_data = 8'(data);
    mirror[addr] = data;
    @(negedge sclock);
    cfg_we = 1'b0;
  endtask

  // Reference model: each step costs PARK+ARM, then the trigger delay (or a
  // skip for entry 0) plus the hold-off; the done cycle follows the last step.
  task automatic issue_run(input int ns, input int nsw, input bit ten, input bit expect_done);
    done_exp_t e;
    int sw;
    bit stop;
    trig_en = ten;
    e.dur = 1; e.trig = 0; e.terr = 0; stop = 1'b0;
    sw = (nsw == 0) ? 1 : nsw;
    if (ns > 0) begin
      for (int s = 0; s < sw && !stop; s++) begin
        for (int i = 0; i < ns && !stop; i++) begin
          e.dur += 2;
          if (mirror[i] == 0) e.dur += MIN_GAP;
          else begin
            exp_arm_q.push_back(mirror[i]);
            exp_idx_q.push_back(i);
            if (ten) begin
              e.dur += mirror[i] + MIN_GAP;
              e.trig++;
            end else begin
              e.dur += TIMEOUT;
              e.terr = 1;
              stop = 1'b1;
            end
          end
        end
      end
    end
    @(negedge sclock);
    n_steps = ns[AW:0]; n_sweeps = nsw[7:0]; start = 1'b1;
    cfg_we = 1'b1;
    cfg_addr = AW'($urandom_range(0, DEPTH - 1));
    cfg_data = 8'($urandom_range(16, 255));
    e.start_cyc = cyc;
    if (expect_done) exp_done_q.push_back(e);
    @(negedge sclock);
    start = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic wait_runs();
    int n;
    n = 0;
    while ((exp_done_q.size() != 0 || busy) && n < 4000) begin
      @(negedge sclock);
      n++;
      cfg_we = 1'b0;
      if (n == 8 && busy) begin
        cfg_we = 1'b1;
        cfg_addr = AW'($urandom_range(0, DEPTH - 1));
        cfg_data = 8'($urandom_range(16, 255));
      end
    end
    cfg_we = 1'b0;
    check("run_completed", exp_done_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_qpd_rt"}, int'(qpd_rt), 0);
    check({tag, "_qpd_count"}, int'(qpd_count), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_timeout_err"}, int'(timeout_err), 0);
    check({tag, "_step_idx"}, int'(step_idx), 0);
    check({tag, "_trig_count"}, int'(trig_count), 0);
  endtask

  initial begin : stimulus
    repeat (3) @(negedge sclock);
    check_all_zero("reset");
    rstn = 1'b1;
    repeat (2) @(negedge sclock);

    write_tbl(0, 5); write_tbl(1, 9);
    issue_run(2, 1, 1'b1, 1'b1); wait_runs();

    write_tbl(0, 7); write_tbl(1, 7);
    issue_run(2, 1, 1'b1, 1'b1); wait_runs();

    write_tbl(0, 40);
    issue_run(1, 1, 1'b0, 1'b1); wait_runs();

    write_tbl(0, 3);
    issue_run(1, 0, 1'b1, 1'b1); wait_runs();

    issue_run(0, 2, 1'b1, 1'b1); wait_runs();

    // Abort in the middle of the hold-off.
    write_tbl(0, 30);
    issue_run(1, 1, 1'b1, 1'b0);
    repeat (40) @(negedge sclock);
    abort = 1'b1;
    @(negedge sclock);
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_qpd_rt", int'(qpd_rt), 0);
    check("abort_qpd_count", int'(qpd_count), 0);
    check("abort_trig_kept", int'(trig_count), 1);
    repeat (30) @(negedge sclock);
    issue_run(1, 1, 1'b1, 1'b1); wait_runs();

    // Reset pulled mid-WAIT must clear outputs without a clock edge.
    write_tbl(0, 60);
    issue_run(1, 1, 1'b1, 1'b0);
    repeat (10) @(negedge sclock);
    check("pre_reset_busy", int'(busy), 1);
    #2 rstn = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge sclock);
    rstn = 1'b1;
    for (int i = 0; i < DEPTH; i++) write_tbl(i, i + 1);
    issue_run(DEPTH, 1, 1'b1, 1'b1); wait_runs();

    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < DEPTH; i++)
        write_tbl(i, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15)));
      issue_run(int'($urandom_range(0, DEPTH)), int'($urandom_range(0, 3)),
                ($urandom_range(0, 4) != 0), 1'b1);
      wait_runs();
    end

    check("arm_queue_drained", exp_arm_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
